// File: rtl/superscalar_pipe_reg.sv
// Inter-stage pipeline register for a multi-lane instruction bundle.
// Valid/ready handshake backed by a 2-entry skid buffer, plus flush and a saturating stall counter.
module superscalar_pipe_reg #(
  parameter int LANES  = 2,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    in_ready,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic [CNT_W-1:0]        stall_count,
  output logic [1:0]              occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                    state_q, state_d;
  logic [LANES-1:0]          main_valid_q, main_valid_d;
  logic [LANES*DATA_W-1:0]   main_data_q, main_data_d;
  logic [LANES-1:0]          skid_valid_q, skid_valid_d;
  logic [LANES*DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]          stall_count_q, stall_count_d;

  logic accept;
  logic pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= EMPTY;
      main_valid_q  <= '0;
      main_data_q   <= '0;
      skid_valid_q  <= '0;
      skid_data_q   <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      main_valid_q  <= main_valid_d;
      main_data_q   <= main_data_d;
      skid_valid_q  <= skid_valid_d;
      skid_data_q   <= skid_data_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Handshake qualifiers; bubbles (all lanes invalid) are never accepted.
  assign accept = in_ready & (|in_valid) & ~flush;
  assign pop    = (|out_valid) & out_ready;

  always_comb begin
    state_d       = state_q;
    main_valid_d  = main_valid_q;
    main_data_d   = main_data_q;
    skid_valid_d  = skid_valid_q;
    skid_data_d   = skid_data_q;
    stall_count_d = stall_count_q;

    if (flush) begin
      state_d      = EMPTY;
      main_valid_d = '0;
      skid_valid_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            main_valid_d = in_valid;
            main_data_d  = in_data;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_valid_d = in_valid;
            main_data_d  = in_data;
          end else if (accept) begin
            state_d      = FULL;
            skid_valid_d = in_valid;
            skid_data_d  = in_data;
          end else if (pop) begin
            state_d      = EMPTY;
            main_valid_d = '0;
          end
        end
        FULL: begin
          // in_ready is low here, so only the skid entry can move forward.
          if (pop) begin
            state_d      = ONE;
            main_valid_d = skid_valid_q;
            main_data_d  = skid_data_q;
            skid_valid_d = '0;
          end
        end
        default: begin
          state_d      = EMPTY;
          main_valid_d = '0;
          skid_valid_d = '0;
        end
      endcase
    end

    if ((|out_valid) && !out_ready && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_comb begin
    in_ready    = (state_q != FULL);
    out_valid   = (state_q == EMPTY) ? '0 : main_valid_q;
    out_data    = main_data_q;
    stall_count = stall_count_q;
    case (state_q)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_superscalar_pipe_reg.sv
// Scoreboard bench for superscalar_pipe_reg (LANES=2, DATA_W=16, CNT_W=4).
// Directed stimulus pushes expected bundles; a negedge monitor pops and compares on every pop.
module tb_superscalar_pipe_reg;

  localparam int LANES  = 2;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;
  localparam int W      = LANES * DATA_W;

  typedef logic [LANES+W-1:0] entry_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [LANES-1:0]  in_valid = '0;
  logic [W-1:0]      in_data = '0;
  logic              in_ready;
  logic [LANES-1:0]  out_valid;
  logic [W-1:0]      out_data;
  logic              out_ready = 1'b0;
  logic              flush = 1'b0;
  logic [CNT_W-1:0]  stall_count;
  logic [1:0]        occupancy;

  entry_t exp_q[$];
  int     checks = 0;
  int     errors = 0;

  superscalar_pipe_reg #(
    .LANES (LANES),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .flush      (flush),
    .stall_count(stall_count),
    .occupancy  (occupancy)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic [LANES-1:0] v, input logic [DATA_W-1:0] d1,
                                input logic [DATA_W-1:0] d0);
    in_valid = v;
    in_data  = {d1, d0};
  endtask

  task automatic push_expected(input logic [LANES-1:0] v, input logic [DATA_W-1:0] d1,
                               input logic [DATA_W-1:0] d0);
    exp_q.push_back({v, d1, d0});
  endtask

  // Every transfer that completes at the next rising edge is compared here.
  always @(negedge clock) begin
    if (!reset && (|out_valid) && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL pop_unexpected: got %h expected none", {out_valid, out_data});
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        if ({out_valid, out_data} !== e) begin
          errors++;
          $display("[TB] FAIL pop_bundle: got %h expected %h", {out_valid, out_data}, e);
        end
      end
    end
  end

  initial begin
    // Power-on reset
    #12;
    reset = 1'b0;
    #1;
    check_output("por_in_ready", 32'(in_ready), 32'd1);
    check_output("por_occupancy", 32'(occupancy), 32'd0);
    check_output("por_out_valid", 32'(out_valid), 32'd0);

    // Reset mid-operation
    apply_stimulus(2'b11, 16'h5678, 16'h1234);
    step();
    apply_stimulus(2'b00, 16'h0000, 16'h0000);
    check_output("load_occupancy", 32'(occupancy), 32'd1);
    check_output("load_out_data", 32'(out_data), 32'h5678_1234);
    #1;
    reset = 1'b1;
    #1;
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_data", 32'(out_data), 32'd0);
    check_output("rst_occupancy", 32'(occupancy), 32'd0);
    reset = 1'b0;
    #1;
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    check_output("rst_stall_count", 32'(stall_count), 32'd0);

    // Streaming with out_ready held high
    step();
    out_ready = 1'b1;
    push_expected(2'b11, 16'h0002, 16'h0001);
    push_expected(2'b11, 16'h0004, 16'h0003);
    push_expected(2'b11, 16'h0006, 16'h0005);
    apply_stimulus(2'b11, 16'h0002, 16'h0001);
    step();
    check_output("stream_a_occ", 32'(occupancy), 32'd1);
    check_output("stream_a_ready", 32'(in_ready), 32'd1);
    apply_stimulus(2'b11, 16'h0004, 16'h0003);
    step();
    check_output("stream_b_occ", 32'(occupancy), 32'd1);
    check_output("stream_b_data", 32'(out_data), 32'h0004_0003);
    apply_stimulus(2'b11, 16'h0006, 16'h0005);
    step();
    check_output("stream_c_occ", 32'(occupancy), 32'd1);
    check_output("stream_c_ready", 32'(in_ready), 32'd1);
    apply_stimulus(2'b00, 16'h0000, 16'h0000);
    step();
    check_output("stream_drain_occ", 32'(occupancy), 32'd0);
    check_output("stream_stall", 32'(stall_count), 32'd0);
    check_output("stream_queue", exp_q.size(), 32'd0);

    // Back-pressure into the skid entry
    out_ready = 1'b0;
    push_expected(2'b11, 16'h00A2, 16'h00A1);
    push_expected(2'b11, 16'h00B2, 16'h00B1);
    push_expected(2'b11, 16'h00C2, 16'h00C1);
    apply_stimulus(2'b11, 16'h00A2, 16'h00A1);
    step();
    apply_stimulus(2'b11, 16'h00B2, 16'h00B1);
    step();
    check_output("bp_occupancy", 32'(occupancy), 32'd2);
    check_output("bp_in_ready", 32'(in_ready), 32'd0);
    check_output("bp_out_data", 32'(out_data), 32'h00A2_00A1);
    apply_stimulus(2'b11, 16'h00C2, 16'h00C1);
    step();
    step();
    check_output("bp_stall_count", 32'(stall_count), 32'd3);
    check_output("bp_hold_occ", 32'(occupancy), 32'd2);
    out_ready = 1'b1;
    step();
    check_output("bp_release_data", 32'(out_data), 32'h00B2_00B1);
    check_output("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    check_output("bp_c_data", 32'(out_data), 32'h00C2_00C1);
    apply_stimulus(2'b00, 16'h0000, 16'h0000);
    step();
    check_output("bp_drain_occ", 32'(occupancy), 32'd0);
    check_output("bp_stall_hold", 32'(stall_count), 32'd3);
    check_output("bp_queue", exp_q.size(), 32'd0);

    // Bubble and partial lanes
    apply_stimulus(2'b00, 16'hDEAD, 16'hDEAD);
    step();
    check_output("bubble_occ", 32'(occupancy), 32'd0);
    check_output("bubble_valid", 32'(out_valid), 32'd0);
    push_expected(2'b10, 16'hBEEF, 16'h0000);
    apply_stimulus(2'b10, 16'hBEEF, 16'h0000);
    step();
    check_output("partial_valid", 32'(out_valid), 32'b10);
    check_output("partial_lane1", 32'(out_data[DATA_W +: DATA_W]), 32'h0000_BEEF);
    apply_stimulus(2'b00, 16'h0000, 16'h0000);
    step();
    check_output("partial_queue", exp_q.size(), 32'd0);

    // Flush while FULL, with a pop and a new bundle in the same cycle
    out_ready = 1'b0;
    push_expected(2'b11, 16'h0A02, 16'h0A01);
    apply_stimulus(2'b11, 16'h0A02, 16'h0A01);
    step();
    apply_stimulus(2'b11, 16'h0B02, 16'h0B01);
    step();
    check_output("flush_pre_occ", 32'(occupancy), 32'd2);
    apply_stimulus(2'b11, 16'h0C02, 16'h0C01);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    apply_stimulus(2'b00, 16'h0000, 16'h0000);
    check_output("flush_out_valid", 32'(out_valid), 32'd0);
    check_output("flush_occ", 32'(occupancy), 32'd0);
    check_output("flush_in_ready", 32'(in_ready), 32'd1);
    step();
    check_output("flush_c_dropped", 32'(occupancy), 32'd0);
    check_output("flush_stall", 32'(stall_count), 32'd4);
    check_output("flush_queue", exp_q.size(), 32'd0);

    // Stall counter saturation
    #1;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    out_ready = 1'b0;
    step();
    apply_stimulus(2'b11, 16'h0F02, 16'h0F01);
    step();
    apply_stimulus(2'b00, 16'h0000, 16'h0000);
    check_output("sat_start", 32'(stall_count), 32'd0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 10) check_output("sat_10", 32'(stall_count), 32'd10);
      if (i == 15) check_output("sat_15", 32'(stall_count), 32'd15);
    end
    check_output("sat_20", 32'(stall_count), 32'd15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_output("sat_flush_keep", 32'(stall_count), 32'd15);
    check_output("sat_flush_occ", 32'(occupancy), 32'd0);
    step();
    check_output("final_queue", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
